// File: rtl/baud_gen_frac.sv
// baud_gen_frac: runtime-programmable fractional-N baud generator.
// A cycle counter runs for len_q clocks per oversample period; a FRAC_W-bit
// accumulator adds the divisor fraction once per period and its carry
// stretches the following period by one clock, so the mean period is
// int + frac/2^FRAC_W clocks.
// Ports:
//   clk       system clock, rising edge
//   rst_n     synchronous reset, active low
//   en        count enable; 0 freezes the phase
//   div_load  1-cycle strobe: load div_in and restart the phase
//   div_in    {int[INT_W-1:0], frac[FRAC_W-1:0]} clocks per ovs tick
//   sync_clr  1-cycle strobe: restart the phase (RX start-bit edge)
//   ovs_tick  1-cycle pulse at OVS x baud
//   baud_tick 1-cycle pulse at baud, coincident with every OVS-th ovs_tick
//   div_cur   active divisor register (raw loaded value, unclamped)
module baud_gen_frac #(
    parameter int unsigned SYS_CLK = 100_000_000,
    parameter int unsigned BAUD    = 9600,
    parameter int unsigned OVS     = 16,
    parameter int unsigned INT_W   = 16,
    parameter int unsigned FRAC_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    div_load,
    input  logic [INT_W+FRAC_W-1:0] div_in,
    input  logic                    sync_clr,
    output logic                    ovs_tick,
    output logic                    baud_tick,
    output logic [INT_W+FRAC_W-1:0] div_cur
);
    localparam int unsigned DW  = INT_W + FRAC_W;
    localparam int unsigned OCW = (OVS > 1) ? $clog2(OVS) : 1;
    localparam logic [63:0] DEF_DIV64 = (64'(SYS_CLK) << FRAC_W) / (64'(BAUD) * 64'(OVS));
    localparam logic [DW-1:0] DEF_DIV = DEF_DIV64[DW-1:0];

    logic [DW-1:0]    div_q;
    logic [INT_W-1:0] cnt;
    logic [INT_W:0]   len_q;   // one extra bit so full-scale int + carry never wraps
    logic [FRAC_W-1:0] facc;
    logic [OCW-1:0]   ocnt;

    logic [INT_W-1:0]  int_q;
    logic [FRAC_W-1:0] frac_q;
    logic [FRAC_W:0]   facc_sum;
    logic              term;
    logic              last_ovs;

    // Periods shorter than 2 clocks cannot produce distinct 1-cycle pulses.
    function automatic logic [INT_W:0] clamp_len(input logic [INT_W-1:0] iv);
        return (iv < INT_W'(2)) ? (INT_W+1)'(2) : {1'b0, iv};
    endfunction

    always_comb begin
        int_q    = div_q[DW-1:FRAC_W];
        frac_q   = div_q[FRAC_W-1:0];
        facc_sum = {1'b0, facc} + {1'b0, frac_q};
        term     = ({1'b0, cnt} == (len_q - (INT_W+1)'(1)));
        last_ovs = (ocnt == OCW'(OVS - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q     <= DEF_DIV;
            cnt       <= '0;
            facc      <= '0;
            ocnt      <= '0;
            len_q     <= clamp_len(DEF_DIV[DW-1:FRAC_W]);
            ovs_tick  <= 1'b0;
            baud_tick <= 1'b0;
        end else if (div_load) begin
            div_q     <= div_in;
            cnt       <= '0;
            facc      <= '0;
            ocnt      <= '0;
            len_q     <= clamp_len(div_in[DW-1:FRAC_W]);
            ovs_tick  <= 1'b0;
            baud_tick <= 1'b0;
        end else if (sync_clr) begin
            cnt       <= '0;
            facc      <= '0;
            ocnt      <= '0;
            len_q     <= clamp_len(int_q);
            ovs_tick  <= 1'b0;
            baud_tick <= 1'b0;
        end else if (en) begin
            ovs_tick  <= term;
            baud_tick <= term & last_ovs;
            if (term) begin
                cnt   <= '0;
                facc  <= facc_sum[FRAC_W-1:0];
                // Carry out of the fraction lengthens the next period by one clock.
                len_q <= clamp_len(int_q) + (INT_W+1)'(facc_sum[FRAC_W]);
                ocnt  <= last_ovs ? '0 : ocnt + OCW'(1);
            end else begin
                cnt <= cnt + INT_W'(1);
            end
        end else begin
            // Phase holds; ticks only ever follow an enabled terminal count.
            ovs_tick  <= 1'b0;
            baud_tick <= 1'b0;
        end
    end

    assign div_cur = div_q;
endmodule

// File: tb/tb_baud_gen_frac.sv
module tb_baud_gen_frac;
    localparam int unsigned SYS_CLK = 100_000_000;
    localparam int unsigned BAUD    = 9600;
    localparam int unsigned OVS     = 16;
    localparam int unsigned INT_W   = 16;
    localparam int unsigned FRAC_W  = 4;
    localparam int unsigned DW      = INT_W + FRAC_W;
    localparam logic [DW-1:0] DEF   = 20'd10416;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0, en = 1'b0, div_load = 1'b0, sync_clr = 1'b0;
    logic [DW-1:0] div_in = '0;
    logic          ovs_tick, baud_tick;
    logic [DW-1:0] div_cur;

    int nvec = 0;
    int nerr = 0;

    // Reference model: tick k (k=1,2,...) after a restart falls on enabled edge
    // k*L + floor((k-1)*frac/2^FRAC_W), with L = max(int,2); every OVS-th tick
    // is also a baud tick.
    logic [DW-1:0] m_div;
    longint        m_e, m_k;
    logic          exp_ovs, exp_baud;

    baud_gen_frac #(.SYS_CLK(SYS_CLK), .BAUD(BAUD), .OVS(OVS), .INT_W(INT_W), .FRAC_W(FRAC_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .div_load(div_load), .div_in(div_in),
        .sync_clr(sync_clr), .ovs_tick(ovs_tick), .baud_tick(baud_tick), .div_cur(div_cur)
    );

    always #5 clk = ~clk;

    function automatic longint tick_time(input logic [DW-1:0] d, input longint k);
        longint l, f;
        l = longint'(d >> FRAC_W);
        if (l < 2) l = 2;
        f = longint'(d % (1 << FRAC_W));
        return k * l + ((k - 1) * f) / (1 << FRAC_W);
    endfunction

    task automatic model(input logic r, input logic e, input logic l, input logic [DW-1:0] d, input logic c);
        exp_ovs  = 1'b0;
        exp_baud = 1'b0;
        if (!r) begin
            m_div = DEF; m_e = 0; m_k = 1;
        end else if (l) begin
            m_div = d; m_e = 0; m_k = 1;
        end else if (c) begin
            m_e = 0; m_k = 1;
        end else if (e) begin
            m_e++;
            if (m_e == tick_time(m_div, m_k)) begin
                exp_ovs  = 1'b1;
                exp_baud = (m_k % OVS) == 0;
                m_k++;
            end
        end
    endtask

    task automatic chk(input string tag, input longint obs, input longint expv);
        nvec++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic l, input logic [DW-1:0] d, input logic c);
        rst_n = r; en = e; div_load = l; div_in = d; sync_clr = c;
        @(posedge clk);
        model(r, e, l, d, c);
        #1;
        nvec++;
        assert (ovs_tick === exp_ovs && baud_tick === exp_baud && div_cur === m_div) else begin
            nerr++;
            $error("FAIL cycle: observed ovs=%b baud=%b div=%h expected ovs=%b baud=%b div=%h",
                   ovs_tick, baud_tick, div_cur, exp_ovs, exp_baud, m_div);
        end
        rst_n = 1'b1; div_load = 1'b0; sync_clr = 1'b0;
    endtask

    task automatic run(input int n, input logic e);
        for (int i = 0; i < n; i++) step(1'b1, e, 1'b0, '0, 1'b0);
    endtask

    // Clocks (with en=1) until the selected tick is seen; -1 if the bound expires.
    task automatic wait_tick(input bit baud, input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            step(1'b1, 1'b1, 1'b0, '0, 1'b0);
            if ((baud ? baud_tick : ovs_tick) === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n, sum;
        logic [DW-1:0] d;

        // Reset state and default timing
        step(1'b0, 1'b0, 1'b0, '0, 1'b0);
        chk("reset_div_cur", div_cur, 10416);
        chk("reset_ovs", ovs_tick, 0);
        chk("reset_baud", baud_tick, 0);
        wait_tick(1'b0, 700, n);   chk("first_ovs", n, 651);
        wait_tick(1'b0, 700, n);   chk("ovs_period", n, 651);
        wait_tick(1'b1, 11000, n); chk("first_baud_reached", (n > 0), 1);
        wait_tick(1'b1, 11000, n); chk("baud_period", n, 10416);

        // Fractional divisor 10 + 8/16
        step(1'b1, 1'b1, 1'b1, 20'h000A8, 1'b0);
        chk("frac_div_cur", div_cur, 'h000A8);
        wait_tick(1'b0, 20, n);    chk("frac_first", n, 10);
        sum = 0;
        for (int i = 0; i < 16; i++) begin
            wait_tick(1'b0, 20, n);
            sum += (n < 0) ? 1000 : n;
        end
        chk("frac_16_ticks", sum, 168);

        // Clamp of int 0 and 1 to period 2
        step(1'b1, 1'b1, 1'b1, 20'h00000, 1'b0);
        chk("int0_div_cur", div_cur, 0);
        wait_tick(1'b0, 10, n);
        wait_tick(1'b0, 10, n);    chk("int0_period", n, 2);
        step(1'b1, 1'b1, 1'b1, 20'h00010, 1'b0);
        chk("int1_div_cur", div_cur, 'h10);
        wait_tick(1'b0, 10, n);
        wait_tick(1'b0, 10, n);    chk("int1_period", n, 2);

        // en low for 50 clocks at cnt=300
        step(1'b0, 1'b0, 1'b0, '0, 1'b0);
        run(300, 1'b1);
        run(50, 1'b0);
        wait_tick(1'b0, 700, n);   chk("en_pause_resume", n, 351);

        // sync_clr mid-frame at ocnt=5
        for (int i = 0; i < 5; i++) wait_tick(1'b0, 700, n);
        run(100, 1'b1);
        step(1'b1, 1'b1, 1'b0, '0, 1'b1);
        wait_tick(1'b0, 700, n);   chk("clr_ovs", n, 651);
        wait_tick(1'b1, 11000, sum);
        chk("clr_baud", (sum < 0) ? -1 : n + sum, 16 * 651);
        run(37, 1'b1);
        step(1'b1, 1'b1, 1'b1, 20'h000A8, 1'b1);
        chk("load_beats_clr", div_cur, 'h000A8);
        wait_tick(1'b0, 20, n);    chk("load_beats_clr_period", n, 10);

        // Reset mid-period after a load
        run(4, 1'b1);
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        chk("midreset_div", div_cur, 10416);
        chk("midreset_ovs", ovs_tick, 0);
        wait_tick(1'b0, 700, n);   chk("midreset_first_ovs", n, 651);

        // Full-scale divisor: loads raw, no early tick
        step(1'b1, 1'b1, 1'b1, 20'hFFFFF, 1'b0);
        run(20, 1'b1);
        chk("fullscale_div", div_cur, 'hFFFFF);

        // Randomized control traffic against the model
        for (int i = 0; i < 6000; i++) begin
            d = {12'(0), 4'($urandom_range(0, 15)), 4'($urandom)};
            step(($urandom_range(0, 799) != 0),
                 ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 199) == 0), d,
                 ($urandom_range(0, 149) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
